// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Fixed-time sequencer for two vehicle signal heads (road A, road B) and one
//   shared pedestrian crossing, with all-red clearance between every road
//   change. A prescaler divides CLK into 1 ms ticks; a phase timer counts ticks.
//   Pedestrian requests are synchronised, edge-detected, latched, and served
//   at the next all-red boundary.
//
//   Optional feature macro: NIGHT_FLASH_EN
//     defined   : en=0 forces FLASH (both yellows blink at 500 ms), en=1 resumes via AR_B
//     undefined : en=0 pauses state, prescaler and timer; FLASH is unreachable
//
// Ports
//   CLK       in   system clock (10 kHz nominal), posedge
//   reset     in   synchronous, active-high
//   en        in   run enable
//   ped_req   in   asynchronous pedestrian button, active-high
//   a_green/a_yellow/a_red   out  road A lamps
//   b_green/b_yellow/b_red   out  road B lamps
//   walk      out  pedestrian walk lamp
//   ped_wait  out  pedestrian request latched, not yet served
//   phase     out  current state code
module intersection_scheduler #(
   parameter int CLK_DIV   = 10,
   parameter int T_GREEN_A = 8000,
   parameter int T_GREEN_B = 5000,
   parameter int T_YELLOW  = 2000,
   parameter int T_ALLRED  = 1000,
   parameter int T_WALK    = 6000,
   parameter int TW        = 16
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       en,
   input  logic       ped_req,
   output logic       a_green,
   output logic       a_yellow,
   output logic       a_red,
   output logic       b_green,
   output logic       b_yellow,
   output logic       b_red,
   output logic       walk,
   output logic       ped_wait,
   output logic [2:0] phase
);

   localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int T_FLASH = 500;

   typedef enum logic [2:0] {
      A_GRN = 3'd0,
      A_YEL = 3'd1,
      AR_A  = 3'd2,
      B_GRN = 3'd3,
      B_YEL = 3'd4,
      AR_B  = 3'd5,
      WALK  = 3'd6,
      FLASH = 3'd7
   } state_t;

   typedef enum logic {
      ROAD_A = 1'b0,
      ROAD_B = 1'b1
   } road_t;

   state_t          state, state_n;
   road_t           after_walk, after_n;
   logic [PW-1:0]   presc, presc_n;
   logic [TW-1:0]   timer, timer_n;
   logic [TW-1:0]   dur_m1;
   logic            pw_n;
   logic [2:0]      sync;
   logic            tick, expire, rise;
`ifdef NIGHT_FLASH_EN
   logic            flash_on, flash_n;
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= AR_B;
         presc      <= '0;
         timer      <= '0;
         ped_wait   <= 1'b0;
         after_walk <= ROAD_A;
         sync       <= '0;
`ifdef NIGHT_FLASH_EN
         flash_on   <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         presc      <= presc_n;
         timer      <= timer_n;
         ped_wait   <= pw_n;
         after_walk <= after_n;
         sync       <= {sync[1:0], ped_req};
`ifdef NIGHT_FLASH_EN
         flash_on   <= flash_n;
`endif
      end
   end

   // Last timer value (in ticks) of the current state.
   always_comb begin
      dur_m1 = '0;
      case (state)
         A_GRN:       dur_m1 = TW'(T_GREEN_A - 1);
         B_GRN:       dur_m1 = TW'(T_GREEN_B - 1);
         A_YEL,B_YEL: dur_m1 = TW'(T_YELLOW - 1);
         AR_A, AR_B:  dur_m1 = TW'(T_ALLRED - 1);
         WALK:        dur_m1 = TW'(T_WALK - 1);
         FLASH:       dur_m1 = TW'(T_FLASH - 1);
         default:     dur_m1 = '0;
      endcase
   end

   always_comb begin
      state_n = state;
      presc_n = presc;
      timer_n = timer;
      after_n = after_walk;
      tick    = (presc == PW'(CLK_DIV - 1));
      expire  = tick && (timer == dur_m1);
      // sync[1] is the synchronised button, sync[2] its previous value
      rise    = sync[1] & ~sync[2];
      pw_n    = ped_wait | (rise && (state != WALK));
`ifdef NIGHT_FLASH_EN
      flash_n = flash_on;
      if (!en) begin
         pw_n = 1'b0;
         if (state != FLASH) begin
            state_n = FLASH;
            presc_n = '0;
            timer_n = '0;
            flash_n = 1'b1;
         end else if (expire) begin
            presc_n = '0;
            timer_n = '0;
            flash_n = ~flash_on;
         end else if (tick) begin
            presc_n = '0;
            timer_n = timer + 1'b1;
         end else begin
            presc_n = presc + 1'b1;
         end
      end else if (state == FLASH) begin
         state_n = AR_B;
         presc_n = '0;
         timer_n = '0;
         pw_n    = 1'b0;
      end else begin
`else
      if (en) begin
`endif
         // Normal fixed-time cycle; both build variants share this body.
         if (expire) begin
            presc_n = '0;
            timer_n = '0;
            case (state)
               A_GRN: state_n = A_YEL;
               A_YEL: state_n = AR_A;
               AR_A: begin
                  if (ped_wait) begin
                     state_n = WALK;
                     after_n = ROAD_B;
                     pw_n    = 1'b0;
                  end else begin
                     state_n = B_GRN;
                  end
               end
               B_GRN: state_n = B_YEL;
               B_YEL: state_n = AR_B;
               AR_B: begin
                  if (ped_wait) begin
                     state_n = WALK;
                     after_n = ROAD_A;
                     pw_n    = 1'b0;
                  end else begin
                     state_n = A_GRN;
                  end
               end
               WALK:    state_n = (after_walk == ROAD_B) ? B_GRN : A_GRN;
               default: state_n = AR_B;
            endcase
         end else if (tick) begin
            presc_n = '0;
            timer_n = timer + 1'b1;
         end else begin
            presc_n = presc + 1'b1;
         end
      end
   end

   // Lamp decode of the registered state.
   always_comb begin
      a_green  = 1'b0;
      a_yellow = 1'b0;
      a_red    = 1'b0;
      b_green  = 1'b0;
      b_yellow = 1'b0;
      b_red    = 1'b0;
      walk     = 1'b0;
      case (state)
         A_GRN: begin a_green = 1'b1; b_red = 1'b1; end
         A_YEL: begin a_yellow = 1'b1; b_red = 1'b1; end
         AR_A, AR_B: begin a_red = 1'b1; b_red = 1'b1; end
         B_GRN: begin a_red = 1'b1; b_green = 1'b1; end
         B_YEL: begin a_red = 1'b1; b_yellow = 1'b1; end
         WALK:  begin a_red = 1'b1; b_red = 1'b1; walk = 1'b1; end
         FLASH: begin
`ifdef NIGHT_FLASH_EN
            a_yellow = flash_on;
            b_yellow = flash_on;
`endif
         end
         default: begin a_red = 1'b1; b_red = 1'b1; end
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with scaled-down timing:
// CLK_DIV=2, greens 8/5, yellow 2, all-red 1, walk 6 ticks, so in CLK cycles
// A_GRN 16, A_YEL 4, AR 2, B_GRN 10, B_YEL 4, WALK 12.
module tb_intersection_scheduler;

   logic       CLK = 1'b0;
   logic       reset, en, ped_req;
   logic       a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk, ped_wait;
   logic [2:0] phase;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // lamp order {a_green,a_yellow,a_red,b_green,b_yellow,b_red,walk}
   localparam logic [6:0] L_AGRN  = 7'b1000010;
   localparam logic [6:0] L_AYEL  = 7'b0100010;
   localparam logic [6:0] L_AR    = 7'b0010010;
   localparam logic [6:0] L_BGRN  = 7'b0011000;
   localparam logic [6:0] L_BYEL  = 7'b0010100;
   localparam logic [6:0] L_WALK  = 7'b0010011;
   localparam logic [6:0] L_FLON  = 7'b0100100;
   localparam logic [6:0] L_FLOFF = 7'b0000000;

   intersection_scheduler #(
      .CLK_DIV   (2),
      .T_GREEN_A (8),
      .T_GREEN_B (5),
      .T_YELLOW  (2),
      .T_ALLRED  (1),
      .T_WALK    (6),
      .TW        (16)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .en       (en),
      .ped_req  (ped_req),
      .a_green  (a_green),
      .a_yellow (a_yellow),
      .a_red    (a_red),
      .b_green  (b_green),
      .b_yellow (b_yellow),
      .b_red    (b_red),
      .walk     (walk),
      .ped_wait (ped_wait),
      .phase    (phase)
   );

   always #5 CLK = ~CLK;

   // Advance n clock edges; at every falling edge check the lamp safety rules.
   task automatic step(input int unsigned n);
      logic safe;
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge CLK);
         safe = !(a_green && b_green) && (!a_green || b_red) && (!b_green || a_red)
                && (!walk || (a_red && b_red));
         vectors++;
         assert (safe === 1'b1) else begin
            miscompares++;
            $error("FAIL safety: observed %b required 1 (lamps %b%b%b %b%b%b walk %b)",
                   safe, a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [2:0] ph, input logic [6:0] lamps,
                      input logic pw);
      logic [10:0] obs, req;
      obs = {phase, a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk, ped_wait};
      req = {ph, lamps, pw};
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s: observed phase/lamps/pw %b required %b", tag, obs, req);
      end
   endtask

   // From the first falling edge after entering ph: check the last cycle of
   // ph, then the first cycle of the following state.
   task automatic dwell(input string tag, input logic [2:0] ph, input logic [6:0] lamps,
                        input logic pw, input int unsigned dur, input logic [2:0] nph,
                        input logic [6:0] nlamps, input logic npw);
      step(dur - 1);
      chk({tag, "_last"}, ph, lamps, pw);
      step(1);
      chk({tag, "_exit"}, nph, nlamps, npw);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; ped_req = 1'b0;
      step(3);
      chk("reset", 3'd5, L_AR, 1'b0);
      reset = 1'b0; en = 1'b1;

      // first all-red, then one full undisturbed cycle
      dwell("arb0",  3'd5, L_AR,   1'b0, 2,  3'd0, L_AGRN, 1'b0);
      dwell("agrn",  3'd0, L_AGRN, 1'b0, 16, 3'd1, L_AYEL, 1'b0);
      dwell("ayel",  3'd1, L_AYEL, 1'b0, 4,  3'd2, L_AR,   1'b0);
      dwell("ara",   3'd2, L_AR,   1'b0, 2,  3'd3, L_BGRN, 1'b0);
      dwell("bgrn",  3'd3, L_BGRN, 1'b0, 10, 3'd4, L_BYEL, 1'b0);
      dwell("byel",  3'd4, L_BYEL, 1'b0, 4,  3'd5, L_AR,   1'b0);
      dwell("arb",   3'd5, L_AR,   1'b0, 2,  3'd0, L_AGRN, 1'b0);

      // one-cycle pulse during A_GRN -> WALK after AR_A -> B_GRN
      step(3);
      ped_req = 1'b1; step(1); ped_req = 1'b0;
      chk("pulse_e1", 3'd0, L_AGRN, 1'b0);
      step(1);
      chk("pulse_e2", 3'd0, L_AGRN, 1'b0);
      step(1);
      chk("pulse_e3", 3'd0, L_AGRN, 1'b1);
      step(9);
      chk("agrn_p_last", 3'd0, L_AGRN, 1'b1);
      step(1);
      chk("agrn_p_exit", 3'd1, L_AYEL, 1'b1);
      dwell("ayel_p", 3'd1, L_AYEL, 1'b1, 4,  3'd2, L_AR,   1'b1);
      dwell("ara_p",  3'd2, L_AR,   1'b1, 2,  3'd6, L_WALK, 1'b0);
      dwell("walk_b", 3'd6, L_WALK, 1'b0, 12, 3'd3, L_BGRN, 1'b0);

      // held button across a whole cycle -> exactly one WALK
      ped_req = 1'b1;
      step(3);
      chk("held_set", 3'd3, L_BGRN, 1'b1);
      step(6);
      chk("bgrn_h_last", 3'd3, L_BGRN, 1'b1);
      step(1);
      chk("bgrn_h_exit", 3'd4, L_BYEL, 1'b1);
      dwell("byel_h",  3'd4, L_BYEL, 1'b1, 4,  3'd5, L_AR,   1'b1);
      dwell("arb_h",   3'd5, L_AR,   1'b1, 2,  3'd6, L_WALK, 1'b0);
      dwell("walk_a",  3'd6, L_WALK, 1'b0, 12, 3'd0, L_AGRN, 1'b0);
      dwell("agrn_h",  3'd0, L_AGRN, 1'b0, 16, 3'd1, L_AYEL, 1'b0);
      dwell("ayel_h",  3'd1, L_AYEL, 1'b0, 4,  3'd2, L_AR,   1'b0);
      dwell("ara_h",   3'd2, L_AR,   1'b0, 2,  3'd3, L_BGRN, 1'b0);
      ped_req = 1'b0;

      // new request in B_GRN, then a pulse inside WALK must be ignored
      step(4);
      ped_req = 1'b1; step(1); ped_req = 1'b0;
      step(2);
      chk("bgrn_req", 3'd3, L_BGRN, 1'b1);
      step(2);
      chk("bgrn_r_last", 3'd3, L_BGRN, 1'b1);
      step(1);
      chk("bgrn_r_exit", 3'd4, L_BYEL, 1'b1);
      dwell("byel_r", 3'd4, L_BYEL, 1'b1, 4, 3'd5, L_AR,   1'b1);
      dwell("arb_r",  3'd5, L_AR,   1'b1, 2, 3'd6, L_WALK, 1'b0);
      step(2);
      ped_req = 1'b1; step(1); ped_req = 1'b0;
      step(3);
      chk("walk_pulse", 3'd6, L_WALK, 1'b0);
      step(5);
      chk("walk_w_last", 3'd6, L_WALK, 1'b0);
      step(1);
      chk("walk_w_exit", 3'd0, L_AGRN, 1'b0);
      dwell("agrn_w", 3'd0, L_AGRN, 1'b0, 16, 3'd1, L_AYEL, 1'b0);
      dwell("ayel_w", 3'd1, L_AYEL, 1'b0, 4,  3'd2, L_AR,   1'b0);
      dwell("ara_w",  3'd2, L_AR,   1'b0, 2,  3'd3, L_BGRN, 1'b0);

      // en=0 four cycles into B_GRN
      step(4);
      en = 1'b0;
`ifdef NIGHT_FLASH_EN
      step(1);
      chk("flash_on", 3'd7, L_FLON, 1'b0);
      step(999);
      chk("flash_on_last", 3'd7, L_FLON, 1'b0);
      step(1);
      chk("flash_off", 3'd7, L_FLOFF, 1'b0);
      en = 1'b1;
      step(1);
      chk("flash_exit", 3'd5, L_AR, 1'b0);
`else
      step(1);
      ped_req = 1'b1; step(1); ped_req = 1'b0;
      step(2);
      chk("pause_req", 3'd3, L_BGRN, 1'b1);
      step(20);
      chk("pause_hold", 3'd3, L_BGRN, 1'b1);
      en = 1'b1;
      step(5);
      chk("resume_last", 3'd3, L_BGRN, 1'b1);
      step(1);
      chk("resume_exit", 3'd4, L_BYEL, 1'b1);
      step(2);
      reset = 1'b1; step(1);
      chk("reset_byel", 3'd5, L_AR, 1'b0);
      reset = 1'b0;
`endif

      // reset in the middle of a WALK that will return to road B
      dwell("arb_t",  3'd5, L_AR,   1'b0, 2,  3'd0, L_AGRN, 1'b0);
      step(2);
      ped_req = 1'b1; step(1); ped_req = 1'b0;
      step(2);
      chk("agrn_t_req", 3'd0, L_AGRN, 1'b1);
      step(10);
      chk("agrn_t_last", 3'd0, L_AGRN, 1'b1);
      step(1);
      chk("agrn_t_exit", 3'd1, L_AYEL, 1'b1);
      dwell("ayel_t", 3'd1, L_AYEL, 1'b1, 4, 3'd2, L_AR,   1'b1);
      dwell("ara_t",  3'd2, L_AR,   1'b1, 2, 3'd6, L_WALK, 1'b0);
      step(5);
      reset = 1'b1; step(1);
      chk("reset_walk", 3'd5, L_AR, 1'b0);
      reset = 1'b0;
      dwell("arb_post", 3'd5, L_AR, 1'b0, 2, 3'd0, L_AGRN, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
